des_perm_pipe: RTL and testbench
================================

DES_PERM_PIPE -- requirements
Module: des_perm_pipe

Interface
REQ-001 Parameter LANES, default 1: number of independent 64-bit blocks per beat (1..4).
REQ-002 Parameter STAGES, default 2: register stages between input and output (1..3).
REQ-003 Parameter TAG_W, default 4: sideband tag width, carried unmodified with each beat.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts the input beat this cycle.
REQ-008 in_mode  input  2  per-beat op: 00 final perm (FP), 01 initial perm (IP), 10/11 bypass.
REQ-009 in_data  input  64*LANES  lane k occupies bits [64k+63:64k].
REQ-010 in_tag  input  TAG_W  sideband.
REQ-011 out_valid  output  1  output beat present.
REQ-012 out_ready  input  1  downstream accepts output beat.
REQ-013 out_data  output  64*LANES  permuted lanes.
REQ-014 out_tag  output  TAG_W  tag of the beat on out_data.
REQ-015 blk_count  output  32  saturating count of 64-bit blocks delivered.

Function
REQ-016 FP SHALL map, for row r=0..7, out[63-8r..56-8r] = in[39-r], in[7-r], in[47-r], in[15-r], in[55-r], in[23-r], in[63-r], in[31-r] (MSB first).
REQ-017 IP SHALL be the exact inverse of FP: FP(IP(x)) = IP(FP(x)) = x for all x.
REQ-018 Bypass SHALL pass each lane unchanged; all lanes of a beat use that beat's in_mode.
REQ-019 Permutation SHALL be applied combinationally before the first stage register; remaining stages only carry data.
REQ-020 A beat is accepted when in_valid && in_ready; delivered when out_valid && out_ready.
REQ-021 Latency from acceptance to out_valid SHALL be exactly STAGES cycles when no backpressure occurs.
REQ-022 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-023 Each stage SHALL load when it is empty or its downstream stage advances this cycle; in_ready = first stage empty or advancing (combinational from out_ready permitted).
REQ-024 With out_ready low and all STAGES full, in_ready SHALL be 0 and no beat SHALL be lost, duplicated or reordered.
REQ-025 out_data/out_tag SHALL stay stable while out_valid && !out_ready.
REQ-026 Simultaneous accept and deliver in a full pipe SHALL keep occupancy constant.
REQ-027 blk_count SHALL increment by LANES per delivered beat and saturate at 32'hFFFF_FFFF (no wrap).
REQ-028 in_valid low SHALL not alter any stage contents.

Reset
REQ-029 While rst is high at a clock edge: all stage valid flags 0, out_valid 0, blk_count 0, out_data 0, out_tag 0.
REQ-030 in_ready SHALL be 0 during reset and 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; none appear after reset.

Structure
REQ-032 Shared package des_perm_pkg SHALL hold the FP index table constant, the mode enumeration, and IP/FP permutation functions (IP table derived as FP inverse).
REQ-033 One sub-module des_perm_stage SHALL implement a single elastic register slot (data, tag, valid, ready); des_perm_pipe instantiates STAGES of them in a chain.
REQ-034 Lanes SHALL be generated by a loop over LANES using the package functions; no per-lane hand-written logic.

Verification
REQ-035 FP, LANES=1: in_data 64'h0000_0000_0000_0001 -> out_data 64'h0000_0000_0000_0040 after STAGES cycles.
REQ-036 IP: in_data 64'h0000_0000_0000_0040 -> 64'h0000_0000_0000_0001; 1000 random x through IP then FP return x.
REQ-037 Bypass, LANES=2: in_data {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98}, mode 10 -> identical output, tag 4'hA preserved.
REQ-038 Backpressure: stream 8 beats with tags 0..7, hold out_ready low 5 cycles after the first 2 -> in_ready drops after STAGES beats queued; tags 0..7 delivered in order, none lost.
REQ-039 Reset mid-stream: assert rst with 2 beats in flight -> out_valid 0 next cycle, blk_count 0, no stale beat after release.
REQ-040 Saturation: preload blk_count near 32'hFFFF_FFFE (force), deliver 2 beats at LANES=1 -> blk_count holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/des_perm_pkg.sv
// des_perm_pkg: shared definitions for the DES permutation pipeline.
//   mode_e       - per-beat operation select (FP, IP, bypass)
//   FP_COL_SRC   - FP index table (source bit per column of row 0)
//   fp_src       - source bit index feeding a given FP output bit
//   fp_perm      - DES final permutation of one 64-bit block
//   ip_perm      - DES initial permutation, built as the inverse of fp_perm
//   perm_lane    - applies the selected mode to one 64-bit block
package des_perm_pkg;

    typedef enum logic [1:0] {
        MODE_FP      = 2'b00,
        MODE_IP      = 2'b01,
        MODE_BYP     = 2'b10,
        MODE_BYP_ALT = 2'b11
    } mode_e;

    // Row r of the FP output (bits 63-8r down to 56-8r, MSB first) takes
    // source bits FP_COL_SRC[j] - r for columns j = 0..7.
    localparam logic [5:0] FP_COL_SRC [8] = '{
        6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31
    };

    function automatic logic [5:0] fp_src(input int o);
        int r;
        int j;
        r = (63 - o) / 8;
        j = (63 - o) % 8;
        return FP_COL_SRC[j] - 6'(r);
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int o = 0; o < 64; o++) begin
            y[o] = x[fp_src(o)];
        end
        return y;
    endfunction

    // Scattering through the same table inverts FP exactly.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int o = 0; o < 64; o++) begin
            y[fp_src(o)] = x[o];
        end
        return y;
    endfunction

    function automatic logic [63:0] perm_lane(input mode_e m, input logic [63:0] x);
        logic [63:0] y;
        case (m)
            MODE_FP: y = fp_perm(x);
            MODE_IP: y = ip_perm(x);
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// des_perm_stage: one elastic register slot (data + tag + valid).
//   clk, rst           clock, synchronous active-high reset
//   i_valid / o_ready  upstream handshake (o_ready: slot can load this cycle)
//   i_data, i_tag      upstream payload
//   o_valid / i_ready  downstream handshake
//   o_data, o_tag      registered payload, held while o_valid && !i_ready
// Handshake: a transfer happens on a rising edge where valid && ready;
// valid never drops and payload never changes until that transfer.
module des_perm_stage
    import des_perm_pkg::*;
#(
    parameter int W     = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_data,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [TAG_W-1:0] r_tag;
    logic             w_load;

    // Load when empty or when the current occupant leaves this cycle.
    assign w_load  = !r_valid || i_ready;
    assign o_ready = w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            // Payload only moves with a real beat; bubbles leave it alone.
            if (i_valid) begin
                r_data <= i_data;
                r_tag  <= i_tag;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_tag   = r_tag;

endmodule

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: LANES-wide DES IP/FP/bypass permutation followed by a
// STAGES-deep elastic register chain, with a saturating block counter.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready is 0 while rst is high
//   in_mode               00 FP, 01 IP, 10/11 bypass (applies to all lanes)
//   in_data, in_tag       lane k at bits [64k+63:64k]; tag rides along unchanged
//   out_valid/out_ready   output handshake
//   out_data, out_tag     permuted lanes and their tag
//   blk_count             64-bit blocks delivered, saturating at all ones
// Handshake: accept on in_valid && in_ready, deliver on out_valid && out_ready,
// both at the rising edge; out_* are held while out_valid && !out_ready.
module des_perm_pipe
    import des_perm_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [64*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic [31:0]           blk_count
);

    localparam int W = 64 * LANES;

    mode_e            w_mode;
    logic [W-1:0]     w_perm;
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [W-1:0]     w_data [STAGES+1];
    logic [TAG_W-1:0] w_tag  [STAGES+1];
    logic [32:0]      w_blk_sum;
    logic [31:0]      r_blk_count;

    assign w_mode = mode_e'(in_mode);

    // Permutation sits in front of the first register; later stages just carry.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_perm[64*k +: 64] = perm_lane(w_mode, in_data[64*k +: 64]);
    end

    assign w_valid[0] = in_valid;
    assign w_data[0]  = w_perm;
    assign w_tag[0]   = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        des_perm_stage #(
            .W     (W),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[s]),
            .o_ready (w_ready[s]),
            .i_data  (w_data[s]),
            .i_tag   (w_tag[s]),
            .o_valid (w_valid[s+1]),
            .i_ready (w_ready[s+1]),
            .o_data  (w_data[s+1]),
            .o_tag   (w_tag[s+1])
        );
    end

    assign w_ready[STAGES] = out_ready;
    assign in_ready        = w_ready[0] && !rst;
    assign out_valid       = w_valid[STAGES];
    assign out_data        = w_data[STAGES];
    assign out_tag         = w_tag[STAGES];

    // One extra bit catches the carry out, which selects saturation.
    assign w_blk_sum = {1'b0, r_blk_count} + 33'(LANES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= '0;
        end else if (out_valid && out_ready) begin
            r_blk_count <= w_blk_sum[32] ? 32'hFFFF_FFFF : w_blk_sum[31:0];
        end
    end

    assign blk_count = r_blk_count;

endmodule

// File: tb/tb_des_perm_pipe.sv
module tb_des_perm_pipe;

  localparam int STG1 = 2;
  localparam int STG2 = 3;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] data;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- dut1: LANES=1, STAGES=2 ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [63:0] in_data, out_data;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] blk_count;
  logic        man_ready, bp_en, bp_rand_val;

  assign out_ready = bp_en ? bp_rand_val : man_ready;

  always @(posedge clk) begin
    #1;
    bp_rand_val = ($urandom_range(0, 3) != 0);
  end

  des_perm_pipe #(.LANES(1), .STAGES(STG1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .blk_count(blk_count)
  );

  // ---------------- dut2: LANES=2, STAGES=3 ----------------
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]   b_in_mode;
  logic [127:0] b_in_data, b_out_data;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [31:0]  b_blk_count;

  des_perm_pipe #(.LANES(2), .STAGES(STG2), .TAG_W(4)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .blk_count(b_blk_count)
  );

  // ---------------- counters ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // FP straight from the row rule; IP found by inverting FP on one-hot probes.
  function automatic logic [63:0] fp_model(input logic [63:0] x);
    logic [63:0] y;
    logic [7:0]  row;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      row = {x[39-r], x[7-r], x[47-r], x[15-r], x[55-r], x[23-r], x[63-r], x[31-r]};
      y[63-8*r -: 8] = row;
    end
    return y;
  endfunction

  function automatic logic [63:0] ip_model(input logic [63:0] x);
    logic [63:0] y, probe, img;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      probe = 64'd1 << i;
      img = fp_model(probe);
      for (int p = 0; p < 64; p++) if (img[p]) y[i] = x[p];
    end
    return y;
  endfunction

  function automatic logic [63:0] mode_model(input logic [1:0] m, input logic [63:0] x);
    if (m == 2'b00) return fp_model(x);
    if (m == 2'b01) return ip_model(x);
    return x;
  endfunction

  // ---------------- scoreboard (dut1) ----------------
  logic [67:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        mon_en = 1'b0;
  logic        held = 1'b0;
  logic [67:0] held_val;
  int          deliv_cnt = 0;
  int          deliv_since_rst = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
      deliv_since_rst = 0;
    end else begin
      if (out_valid && out_ready) deliv_since_rst++;
      if (mon_en) begin
        if (held) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_stable", {out_tag, out_data}, held_val);
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got tag=%h data=%h, required no beat", out_tag, out_data);
          end else begin
            check("stream_beat", {out_tag, out_data}, exp_q.pop_front());
          end
          got_q.push_back(out_data);
          deliv_cnt++;
        end else if (out_valid) begin
          held = 1'b1;
          held_val = {out_tag, out_data};
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle1();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] m, input logic [63:0] d, input logic [3:0] t,
                           input logic [63:0] e);
    int w = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_mode = m;
    in_data = d;
    in_tag = t;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({t, e});
        break;
      end
      w++;
      if (w > 300) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 300 cycles");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Single beat through an empty pipe: latency, data and tag.
  task automatic apply_vec(input vec_t v, input bit on2, input string name);
    int lat;
    int stg;
    logic ov;
    stg = on2 ? STG2 : STG1;
    @(posedge clk);
    #1;
    if (on2) begin
      b_in_valid = 1'b1; b_in_mode = v.mode; b_in_data = v.data; b_in_tag = v.tag;
    end else begin
      in_valid = 1'b1; in_mode = v.mode; in_data = v.data[63:0]; in_tag = v.tag;
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    in_valid = 1'b0;
    lat = 1;
    ov = on2 ? b_out_valid : out_valid;
    while (!ov && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      ov = on2 ? b_out_valid : out_valid;
    end
    check({name, "_latency"}, lat, stg);
    if (on2) begin
      check({name, "_data"}, b_out_data, v.exp);
      check({name, "_tag"}, b_out_tag, v.tag);
    end else begin
      check({name, "_data"}, out_data, v.exp[63:0]);
      check({name, "_tag"}, out_tag, v.tag);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  vec_t v1[8];
  vec_t v2[4];
  logic [63:0] xs[$];
  logic [63:0] ys[$];

  initial begin
    logic [63:0] x, a, b;
    logic [1:0]  m;
    int base, acc, stale;
    logic last_rdy;

    rst = 1'b1;
    in_valid = 1'b0; in_mode = 2'b00; in_data = '0; in_tag = '0;
    man_ready = 1'b0; bp_en = 1'b0;
    b_in_valid = 1'b0; b_in_mode = 2'b00; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b0;

    v1[0] = '{mode: 2'b00, data: 128'h1, tag: 4'h3, exp: 128'h40};
    v1[1] = '{mode: 2'b01, data: 128'h40, tag: 4'h5, exp: 128'h1};
    v1[2] = '{mode: 2'b00, data: 128'h0000_0080_0000_0000, tag: 4'h1, exp: 128'h8000_0000_0000_0000};
    v1[3] = '{mode: 2'b01, data: 128'h8000_0000_0000_0000, tag: 4'h2, exp: 128'h0000_0080_0000_0000};
    v1[4] = '{mode: 2'b00, data: 128'h8000_0000_0000_0000, tag: 4'h6, exp: 128'h0200_0000_0000_0000};
    v1[5] = '{mode: 2'b00, data: 128'hFFFF_FFFF_FFFF_FFFF, tag: 4'hF, exp: 128'hFFFF_FFFF_FFFF_FFFF};
    v1[6] = '{mode: 2'b10, data: 128'h0123_4567_89AB_CDEF, tag: 4'h7, exp: 128'h0123_4567_89AB_CDEF};
    v1[7] = '{mode: 2'b11, data: 128'hCAFE_F00D_1234_5678, tag: 4'h8, exp: 128'hCAFE_F00D_1234_5678};

    v2[0] = '{mode: 2'b10, data: {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98}, tag: 4'hA,
              exp: {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98}};
    v2[1] = '{mode: 2'b00, data: {64'h1, 64'h0000_0080_0000_0000}, tag: 4'h3,
              exp: {64'h40, 64'h8000_0000_0000_0000}};
    v2[2] = '{mode: 2'b01, data: {64'h8000_0000_0000_0000, 64'h40}, tag: 4'hC,
              exp: {64'h0000_0080_0000_0000, 64'h1}};
    v2[3] = '{mode: 2'b11, data: {64'h0F0F_0F0F_0F0F_0F0F, 64'h5555_AAAA_3333_CCCC}, tag: 4'h9,
              exp: {64'h0F0F_0F0F_0F0F_0F0F, 64'h5555_AAAA_3333_CCCC}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_blk_count", blk_count, 32'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", out_tag, 4'd0);
    check("rst_b_in_ready", b_in_ready, 1'b0);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);
    check("b_ready_after_rst", b_in_ready, 1'b1);

    // Table-driven vectors
    man_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) apply_vec(v1[i], 1'b0, $sformatf("vec1_%0d", i));
    for (int i = 0; i < 4; i++) apply_vec(v2[i], 1'b1, $sformatf("vec2_%0d", i));
    for (int i = 0; i < 16; i++) begin
      vec_t rv;
      m = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      rv.mode = m;
      rv.data = {a, b};
      rv.tag = 4'($urandom_range(0, 15));
      rv.exp = {mode_model(m, a), mode_model(m, b)};
      apply_vec(rv, 1'b1, "rand2");
    end
    repeat (4) @(posedge clk);
    #1;
    check("b_blk_count_lanes2", b_blk_count, 32'd40);

    // Random stream with random backpressure and gaps
    mon_en = 1'b1;
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      m = 2'($urandom_range(0, 3));
      x = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) idle1();
      send_beat(m, x, 4'($urandom_range(0, 15)), mode_model(m, x));
    end
    idle1();
    wait_drain("random");

    // IP then FP round trip on 1000 random blocks
    got_q.delete();
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      xs.push_back(x);
      send_beat(2'b01, x, 4'(i), ip_model(x));
    end
    idle1();
    wait_drain("ip_pass");
    check("ip_pass_count", got_q.size(), 1000);
    ys = got_q;
    for (int i = 0; i < ys.size(); i++) send_beat(2'b00, ys[i], 4'(i), xs[i]);
    idle1();
    wait_drain("fp_pass");
    bp_en = 1'b0;
    man_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("blk_count_total", blk_count, 32'(deliv_since_rst));

    // Backpressure: 8 tagged beats, stall 5 cycles after 2 delivered
    base = deliv_cnt;
    acc = 0;
    last_rdy = 1'b1;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          x = {$urandom, $urandom};
          send_beat(2'b00, x, 4'(t), fp_model(x));
        end
        idle1();
      end
      begin
        int w = 0;
        while (deliv_cnt < base + 2 && w < 100) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
          last_rdy = in_ready;
        end
        check("bp_in_ready_low", last_rdy, 1'b0);
        check("bp_out_valid_held", out_valid, 1'b1);
        check("bp_accepts_le_stages", (acc <= STG1), 1'b1);
        @(posedge clk);
        #1;
        man_ready = 1'b1;
      end
    join
    wait_drain("bp");
    check("bp_delivered", deliv_cnt - base, 8);

    // Reset with two beats in flight
    man_ready = 1'b0;
    send_beat(2'b10, 64'h1111_2222_3333_4444, 4'h1, 64'h1111_2222_3333_4444);
    send_beat(2'b10, 64'h5555_6666_7777_8888, 4'h2, 64'h5555_6666_7777_8888);
    idle1();
    @(negedge clk);
    check("inflight_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_blk_count", blk_count, 32'd0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_data", out_data, 64'd0);
    rst = 1'b0;
    man_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_after_rst", stale, 0);

    // Saturation of blk_count
    force dut1.r_blk_count = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut1.r_blk_count;
    for (int i = 0; i < 2; i++) begin
      x = {$urandom, $urandom};
      send_beat(2'b00, x, 4'(i), fp_model(x));
    end
    idle1();
    wait_drain("sat");
    repeat (2) @(posedge clk);
    #1;
    check("sat_blk_count", blk_count, 32'hFFFF_FFFF);
    x = {$urandom, $urandom};
    send_beat(2'b01, x, 4'h5, ip_model(x));
    idle1();
    wait_drain("sat2");
    repeat (2) @(posedge clk);
    #1;
    check("sat_blk_count_hold", blk_count, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
